// File: rtl/control_pipe_stager.sv
// control_pipe_stager: carries decode control through ID/EX, EX/MEM, MEM/WB
// and derives load-use stall, branch flush, EX forwarding selects and halt.
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   CONTROL_PIPE/ALU_OP decode-stage control bundle and ALU op
//   ID_VALID/RS1/RS2/RD decode-stage instruction fields
//   BRANCH_TAKEN        EX-stage taken branch or jump
//   STALL, FLUSH        hazard controls toward IF/ID
//   EX_*/MEM_*/WB_*     pipeline register contents per stage
//   FWD_A, FWD_B        EX operand sources (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   HALTED              sticky flag, set once a halt reaches WB
module control_pipe_stager #(
    parameter int REG_AW = 3,
    parameter int CTRL_W = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CTRL_W-1:0] CONTROL_PIPE,
    input  logic [1:0]        ALU_OP,
    input  logic              ID_VALID,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              BRANCH_TAKEN,
    output logic              STALL,
    output logic              FLUSH,
    output logic [CTRL_W-1:0] EX_CTRL,
    output logic [1:0]        EX_ALU_OP,
    output logic [REG_AW-1:0] EX_RD,
    output logic [CTRL_W-1:0] MEM_CTRL,
    output logic [REG_AW-1:0] MEM_RD,
    output logic [CTRL_W-1:0] WB_CTRL,
    output logic [REG_AW-1:0] WB_RD,
    output logic [1:0]        FWD_A,
    output logic [1:0]        FWD_B,
    output logic              HALTED
);

    localparam int B_REG_WRITE = 8;
    localparam int B_MEM_READ  = 6;
    localparam int B_HALT      = 0;

    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              halt_q;
    logic              load_id;
    logic              ex_hit;

    // A halt counts as soon as it sits in WB, and stays latched afterwards.
    assign HALTED = halt_q | WB_CTRL[B_HALT];

    assign ex_hit = (EX_RD == ID_RS1) || (EX_RD == ID_RS2);

    assign STALL = ID_VALID && EX_CTRL[B_MEM_READ]
                   && (EX_RD != '0) && ex_hit;

    assign FLUSH = BRANCH_TAKEN;

    // Flush outranks stall; both, halt and an empty decode slot insert a bubble.
    assign load_id = ID_VALID && !BRANCH_TAKEN && !STALL && !HALTED;

    always_ff @(posedge CLK) begin
        if (RST) begin
            EX_CTRL   <= '0;
            EX_ALU_OP <= '0;
            EX_RD     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
        end else if (load_id) begin
            EX_CTRL   <= CONTROL_PIPE;
            EX_ALU_OP <= ALU_OP;
            EX_RD     <= ID_RD;
            ex_rs1    <= ID_RS1;
            ex_rs2    <= ID_RS2;
        end else begin
            EX_CTRL   <= '0;
            EX_ALU_OP <= '0;
            EX_RD     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_CTRL <= '0;
            MEM_RD   <= '0;
            WB_CTRL  <= '0;
            WB_RD    <= '0;
            halt_q   <= 1'b0;
        end else begin
            MEM_CTRL <= EX_CTRL;
            MEM_RD   <= EX_RD;
            WB_CTRL  <= MEM_CTRL;
            WB_RD    <= MEM_RD;
            halt_q   <= HALTED;
        end
    end

    logic mem_wr;
    logic wb_wr;

    assign mem_wr = MEM_CTRL[B_REG_WRITE] && (MEM_RD != '0);
    assign wb_wr  = WB_CTRL[B_REG_WRITE] && (WB_RD != '0);

    // The younger EX/MEM result wins when both stages write the same register.
    always_comb begin
        FWD_A = 2'b00;
        FWD_B = 2'b00;
        if (mem_wr && (MEM_RD == ex_rs1)) begin
            FWD_A = 2'b01;
        end else if (wb_wr && (WB_RD == ex_rs1)) begin
            FWD_A = 2'b10;
        end
        if (mem_wr && (MEM_RD == ex_rs2)) begin
            FWD_B = 2'b01;
        end else if (wb_wr && (WB_RD == ex_rs2)) begin
            FWD_B = 2'b10;
        end
    end

endmodule
